// File: rtl/psram_resp_pkg.sv
// psram_resp_pkg: shared state encoding, timing formulas and refresh constants
// for the PSRAM responder and its storage.
package psram_resp_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Refresh counter runs at FREQ/REFRESH_HZ cycles per period (4 us).
  localparam int REFRESH_HZ     = 250_000;
  // The first REFRESH_WINDOW cycles of every refresh period force 2x timing.
  localparam int REFRESH_WINDOW = 16;

  // Power-up busy time in clk cycles.
  function automatic int init_cycles(input int freq, input int init_us);
    return (freq / 1_000_000) * init_us;
  endfunction

  // Busy length of a write: 2 + LATENCY (1x) or 2 + 2*LATENCY (2x).
  function automatic int wr_cyc(input int latency, input logic x2);
    return 2 + (x2 ? 2 * latency : latency);
  endfunction

  // Busy length of a read: 8 + LATENCY (1x) or 8 + 2*LATENCY (2x).
  function automatic int rd_cyc(input int latency, input logic x2);
    return 8 + (x2 ? 2 * latency : latency);
  endfunction

  // Refresh period in clk cycles.
  function automatic int refresh_period(input int freq);
    return freq / REFRESH_HZ;
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: 2^AW x 16 single-port RAM with per-byte write enables and a
// registered read port, written so it maps onto block RAM. Contents are never
// cleared; there is deliberately no reset on the array or the read register.
module psram_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [0:(1<<AW)-1];
  logic [15:0] r_rdata;

  // Byte-lane writes plus read-before-write registered read of the same word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/psram_responder.sv
// psram_responder: cycle-level emulation of a PSRAM behind a simple strobe
// interface (power-up busy, fixed write/read busy lengths, word/byte writes).
// Optional macro PSRAM_RESP_LAT2X_EN: adds a free-running refresh counter and
// doubles the latency part of commands accepted inside its refresh window.
module psram_responder
  import psram_resp_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int FREQ      = 67_500_000,
  parameter int ADDR_BITS = 11,
  parameter int INIT_US   = 150
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        read,
  input  logic        write,
  input  logic        byte_write,
  input  logic [21:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy
);

  localparam int INIT_CYCLES = init_cycles(FREQ, INIT_US);
  localparam int INIT_CW     = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int LAT_CW      = $clog2(rd_cyc(LATENCY, 1'b1) + 1);
  localparam int WA          = ADDR_BITS - 1;

  // The latency counter is loaded with length-1 and the command completes
  // on the edge where it reads zero, so busy stays high for exactly length.
  localparam logic [LAT_CW-1:0] WR1_LOAD = LAT_CW'(wr_cyc(LATENCY, 1'b0) - 1);
  localparam logic [LAT_CW-1:0] WR2_LOAD = LAT_CW'(wr_cyc(LATENCY, 1'b1) - 1);
  localparam logic [LAT_CW-1:0] RD1_LOAD = LAT_CW'(rd_cyc(LATENCY, 1'b0) - 1);
  localparam logic [LAT_CW-1:0] RD2_LOAD = LAT_CW'(rd_cyc(LATENCY, 1'b1) - 1);

  state_t              r_state;
  logic [INIT_CW-1:0]  r_init_cnt;
  logic [LAT_CW-1:0]   r_lat_cnt;
  logic [WA-1:0]       r_addr;
  logic                r_lane;
  logic                r_byte;
  logic [15:0]         r_din;
  logic [15:0]         r_dout;
  logic                r_busy;

  logic                w_x2;
  logic [LAT_CW-1:0]   w_wr_load;
  logic [LAT_CW-1:0]   w_rd_load;
  logic [1:0]          w_we;
  logic [15:0]         w_rdata;
  logic                w_unused_addr;

  // Address bits above the backed range simply alias.
  assign w_unused_addr = ^addr[21:ADDR_BITS];

`ifdef PSRAM_RESP_LAT2X_EN
  localparam int REF_PERIOD = refresh_period(FREQ);
  localparam int REF_CW     = (REF_PERIOD < 2) ? 1 : $clog2(REF_PERIOD);

  logic [REF_CW-1:0] r_ref_cnt;

  // Free-running refresh phase; runs in every state, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt == REF_CW'(REF_PERIOD - 1)) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_x2 = (int'(r_ref_cnt) < REFRESH_WINDOW);
`else
  assign w_x2 = 1'b0;
`endif

  assign w_wr_load = w_x2 ? WR2_LOAD : WR1_LOAD;
  assign w_rd_load = w_x2 ? RD2_LOAD : RD1_LOAD;

  // Byte enables fire only on the final WRITE cycle, i.e. the edge busy falls.
  always_comb begin
    w_we = 2'b00;
    if (r_state == ST_WRITE && r_lat_cnt == '0) begin
      if (r_byte) begin
        w_we = r_lane ? 2'b10 : 2'b01;
      end else begin
        w_we = 2'b11;
      end
    end
  end

  psram_resp_mem #(
    .AW (WA)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  // Main controller: power-up wait, command acceptance and latency countdown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_INIT;
      r_busy     <= 1'b1;
      r_dout     <= 16'h0000;
      r_init_cnt <= '0;
      r_lat_cnt  <= '0;
      r_addr     <= '0;
      r_lane     <= 1'b0;
      r_byte     <= 1'b0;
      r_din      <= 16'h0000;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_CW'(INIT_CYCLES)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // Write wins a collision; the read is simply dropped.
          if (!r_busy && (read || write)) begin
            r_state   <= write ? ST_WRITE : ST_READ;
            r_lat_cnt <= write ? w_wr_load : w_rd_load;
            r_addr    <= addr[ADDR_BITS-1:1];
            r_lane    <= addr[0];
            r_byte    <= byte_write;
            r_din     <= din;
            r_busy    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_lat_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_READ: begin
          // RAM has been reading r_addr since acceptance, so w_rdata is valid.
          if (r_lat_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dout  <= w_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign dout = r_dout;

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: two responders share all inputs. DUT A uses
// FREQ=1 MHz/INIT_US=10, DUT B FREQ=10 MHz/INIT_US=1 (both 10 init cycles);
// their refresh periods differ (4 vs 40 cycles) when PSRAM_RESP_LAT2X_EN is set.
module tb_psram_responder;

  localparam int LAT   = 3;
  localparam int AB    = 11;
  localparam int PER_A = 1_000_000 / 250_000;
  localparam int PER_B = 10_000_000 / 250_000;
  localparam int INIT_EXP = 10;
`ifdef PSRAM_RESP_LAT2X_EN
  localparam bit LAT2X = 1'b1;
`else
  localparam bit LAT2X = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        bw = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout_w [2];
  logic        busy_w [2];

  psram_responder #(.LATENCY(LAT), .FREQ(1_000_000), .ADDR_BITS(AB), .INIT_US(10)) u_dut_a (
    .clk(clk), .resetn(resetn), .read(rd), .write(wr), .byte_write(bw),
    .addr(addr), .din(din), .dout(dout_w[0]), .busy(busy_w[0]));

  psram_responder #(.LATENCY(LAT), .FREQ(10_000_000), .ADDR_BITS(AB), .INIT_US(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .read(rd), .write(wr), .byte_write(bw),
    .addr(addr), .din(din), .dout(dout_w[1]), .busy(busy_w[1]));

  always #5 clk = ~clk;

  // Edges since reset release; equals the refresh counter phase before an edge.
  int cyc;
  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte-addressed storage and the last completed read.
  logic [7:0]  mem_m [0:(1<<AB)-1];
  logic [15:0] dout_m = 16'h0000;
  int          m_len [2];
  int          m_acc;

  function automatic int per_of(input int k);
    return (k == 0) ? PER_A : PER_B;
  endfunction

  function automatic int exp_len(input bit is_wr, input int acc, input int per);
    int mult;
    mult = (LAT2X && (acc % per) < 16) ? 2 : 1;
    return (is_wr ? 2 : 8) + LAT * mult;
  endfunction

  function automatic void model_write(input logic [21:0] a, input logic [15:0] d, input bit b);
    logic [10:0] ba;
    ba = a[10:0];
    if (!b) begin
      mem_m[{ba[10:1], 1'b0}] = d[7:0];
      mem_m[{ba[10:1], 1'b1}] = d[15:8];
    end else if (ba[0]) begin
      mem_m[ba] = d[15:8];
    end else begin
      mem_m[ba] = d[7:0];
    end
  endfunction

  function automatic logic [15:0] model_word(input logic [21:0] a);
    logic [10:0] ba;
    ba = a[10:0];
    return {mem_m[{ba[10:1], 1'b1}], mem_m[{ba[10:1], 1'b0}]};
  endfunction

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy_w[0] || busy_w[1]) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout busy=%b%b required 00", busy_w[0], busy_w[1]);
    end
  endtask

  // Issue one command once both DUTs are idle (optionally at a given refresh
  // phase of DUT B), scramble the inputs right after acceptance and measure
  // the busy length of each DUT into m_len.
  task automatic do_cmd(input bit r, input bit w, input bit b, input logic [21:0] a,
                        input logic [15:0] d, input int phase);
    int  n [2];
    bit  done [2];
    int  g;
    @(negedge clk);
    wait_idle();
    g = 0;
    while (phase >= 0 && (cyc % PER_B) != phase && g < 100) begin
      @(negedge clk);
      g++;
    end
    rd = r; wr = w; bw = b; addr = a; din = d; m_acc = cyc;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; bw = 1'($urandom); addr = 22'($urandom); din = 16'($urandom);
    n[0] = 0; n[1] = 0; done[0] = 1'b0; done[1] = 1'b0;
    for (int s = 0; s < 60; s++) begin
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (busy_w[k]) n[k]++;
          else           done[k] = 1'b1;
        end
      end
      if (done[0] && done[1]) break;
      @(negedge clk);
    end
    m_len[0] = n[0]; m_len[1] = n[1];
    $display("[TB] cmd rd=%0d wr=%0d bw=%0d addr=%06h din=%04h phase=%0d busy=%0d/%0d dout=%04h/%04h",
             r, w, b, a, d, m_acc, n[0], n[1], dout_w[0], dout_w[1]);
  endtask

  // Count busy-high samples after reset release.
  task automatic release_and_count_init(input string tag);
    int  n [2];
    bit  done [2];
    n[0] = 0; n[1] = 0; done[0] = 1'b0; done[1] = 1'b0;
    resetn = 1'b1;
    for (int s = 0; s < 50 && !(done[0] && done[1]); s++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (busy_w[k]) n[k]++;
          else           done[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (n[k] !== INIT_EXP) begin
        n_fail++;
        $display("FAIL %s dut%0d busy cycles got %0d required %0d", tag, k, n[k], INIT_EXP);
      end
    end
    $display("[TB] init %s busy=%0d/%0d", tag, n[0], n[1]);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (busy_w[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_busy dut%0d got %b required 1", k, busy_w[k]);
      end
      n_tests++;
      if (dout_w[k] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_dout dut%0d got %04h required 0000", k, dout_w[k]);
      end
    end
    release_and_count_init("power_up");
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== 16'h0000) begin
        n_fail++; $display("FAIL init_dout dut%0d got %04h required 0000", k, dout_w[k]);
      end
    end
  endtask

  task automatic test_word_write_read();
    do_cmd(1'b0, 1'b1, 1'b0, 22'h000010, 16'hA55A, -1);
    model_write(22'h000010, 16'hA55A, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (m_len[k] !== exp_len(1'b1, m_acc, per_of(k))) begin
        n_fail++; $display("FAIL word_write_busy dut%0d got %0d required %0d", k, m_len[k], exp_len(1'b1, m_acc, per_of(k)));
      end
    end
    do_cmd(1'b1, 1'b0, 1'b0, 22'h000010, 16'h0000, -1);
    dout_m = model_word(22'h000010);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (m_len[k] !== exp_len(1'b0, m_acc, per_of(k))) begin
        n_fail++; $display("FAIL word_read_busy dut%0d got %0d required %0d", k, m_len[k], exp_len(1'b0, m_acc, per_of(k)));
      end
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL word_read_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
  endtask

  task automatic test_byte_write();
    do_cmd(1'b0, 1'b1, 1'b0, 22'h000020, 16'h1234, -1);
    model_write(22'h000020, 16'h1234, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b1, 22'h000021, 16'hBEEF, -1);
    model_write(22'h000021, 16'hBEEF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (m_len[k] !== exp_len(1'b1, m_acc, per_of(k))) begin
        n_fail++; $display("FAIL byte_write_busy dut%0d got %0d required %0d", k, m_len[k], exp_len(1'b1, m_acc, per_of(k)));
      end
    end
    do_cmd(1'b1, 1'b0, 1'b0, 22'h000020, 16'h0000, -1);
    dout_m = model_word(22'h000020);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL byte_write_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
  endtask

  task automatic test_collision();
    int extra [2];
    // Both strobes: write wins, dout must keep the previous read value.
    do_cmd(1'b1, 1'b1, 1'b0, 22'h000040, 16'h00FF, -1);
    model_write(22'h000040, 16'h00FF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (m_len[k] !== exp_len(1'b1, m_acc, per_of(k))) begin
        n_fail++; $display("FAIL collision_busy dut%0d got %0d required %0d", k, m_len[k], exp_len(1'b1, m_acc, per_of(k)));
      end
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL collision_dout dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
    // Read strobe raised while busy must be neither executed nor queued.
    @(negedge clk);
    wait_idle();
    wr = 1'b1; bw = 1'b0; addr = 22'h000042; din = 16'h1111;
    @(negedge clk);
    wr = 1'b0; rd = 1'b1; addr = 22'h000040;
    repeat (3) @(negedge clk);
    rd = 1'b0;
    wait_idle();
    model_write(22'h000042, 16'h1111, 1'b0);
    extra[0] = 0; extra[1] = 0;
    repeat (15) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (busy_w[k]) extra[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (extra[k] !== 0) begin
        n_fail++; $display("FAIL ignored_strobe_busy dut%0d got %0d busy cycles required 0", k, extra[k]);
      end
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL ignored_strobe_dout dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
    do_cmd(1'b1, 1'b0, 1'b0, 22'h000042, 16'h0000, -1);
    dout_m = model_word(22'h000042);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL busy_write_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
  endtask

  task automatic test_alias();
    do_cmd(1'b0, 1'b1, 1'b0, 22'h000800, 16'h7777, -1);
    model_write(22'h000800, 16'h7777, 1'b0);
    do_cmd(1'b1, 1'b0, 1'b0, 22'h000000, 16'h0000, -1);
    dout_m = model_word(22'h000000);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL alias_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_cmd(1'b0, 1'b1, 1'b0, 22'h000060, 16'hC3C3, -1);
    model_write(22'h000060, 16'hC3C3, 1'b0);
    @(negedge clk);
    wait_idle();
    rd = 1'b1; addr = 22'h000060;
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    dout_m = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL abort_dout dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
      n_tests++;
      if (busy_w[k] !== 1'b1) begin
        n_fail++; $display("FAIL abort_busy dut%0d got %b required 1", k, busy_w[k]);
      end
    end
    repeat (2) @(negedge clk);
    release_and_count_init("after_abort");
    do_cmd(1'b1, 1'b0, 1'b0, 22'h000060, 16'h0000, -1);
    dout_m = model_word(22'h000060);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dout_w[k] !== dout_m) begin
        n_fail++; $display("FAIL retained_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
      end
    end
  endtask

  task automatic test_lat2x();
    int phases [2];
    phases[0] = 2; phases[1] = 25;
    for (int p = 0; p < 2; p++) begin
      do_cmd(1'b1, 1'b0, 1'b0, 22'h000010, 16'h0000, phases[p]);
      dout_m = model_word(22'h000010);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (m_len[k] !== exp_len(1'b0, m_acc, per_of(k))) begin
          n_fail++; $display("FAIL lat2x_busy dut%0d phase=%0d got %0d required %0d", k, m_acc, m_len[k], exp_len(1'b0, m_acc, per_of(k)));
        end
        n_tests++;
        if (dout_w[k] !== dout_m) begin
          n_fail++; $display("FAIL lat2x_data dut%0d got %04h required %04h", k, dout_w[k], dout_m);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] pool [6];
    logic [21:0] a;
    logic [15:0] d;
    int          op;
    bit          both;
    for (int i = 0; i < 6; i++) begin
      pool[i] = 11'($urandom_range(0, 1023) * 2);
      a = {11'($urandom), pool[i]};
      d = 16'($urandom);
      do_cmd(1'b0, 1'b1, 1'b0, a, d, -1);
      model_write(a, d, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      a = {11'($urandom), pool[$urandom_range(0, 5)]};
      a[0] = 1'($urandom);
      d = 16'($urandom);
      op = $urandom_range(0, 2);
      both = ($urandom_range(0, 3) == 0);
      if (op == 0) begin
        do_cmd(both, 1'b1, 1'b0, a, d, -1);
        model_write(a, d, 1'b0);
      end else if (op == 1) begin
        do_cmd(both, 1'b1, 1'b1, a, d, -1);
        model_write(a, d, 1'b1);
      end else begin
        do_cmd(1'b1, 1'b0, 1'($urandom), a, d, -1);
        dout_m = model_word(a);
      end
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (m_len[k] !== exp_len(op != 2, m_acc, per_of(k))) begin
          n_fail++; $display("FAIL random_busy dut%0d txn=%0d got %0d required %0d", k, i, m_len[k], exp_len(op != 2, m_acc, per_of(k)));
        end
        n_tests++;
        if (dout_w[k] !== dout_m) begin
          n_fail++; $display("FAIL random_dout dut%0d txn=%0d got %04h required %04h", k, i, dout_w[k], dout_m);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_collision();
    test_alias();
    test_reset_abort();
    test_lat2x();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
